alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle RV32I register-register ALU.
- Executes the eight RV32I funct3 operations plus SUB and SRA, selected by the funct7[5] "alt" bit.
- Operand width and pipeline depth are parameters.
- Uses valid/ready handshakes on both sides, per-op tags and synchronous flush, so it can sit between decode and writeback in a stalling pipeline.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_pipe_slice.sv | 37 +++
 rtl/alu_pipe.sv | 150 +++++++++++++++
 tb/tb_alu_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined RV32I register-register ALU:
// funct3 encodings, the decoded operation enum and the decode function.
package alu_pkg;

    localparam logic [2:0] FUNCT3_ADD  = 3'd0;
    localparam logic [2:0] FUNCT3_SLL  = 3'd1;
    localparam logic [2:0] FUNCT3_SLT  = 3'd2;
    localparam logic [2:0] FUNCT3_SLTU = 3'd3;
    localparam logic [2:0] FUNCT3_XOR  = 3'd4;
    localparam logic [2:0] FUNCT3_SRL  = 3'd5;
    localparam logic [2:0] FUNCT3_OR   = 3'd6;
    localparam logic [2:0] FUNCT3_AND  = 3'd7;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    // alt (funct7[5]) only matters for the ADD/SUB and SRL/SRA pairs.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            FUNCT3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            FUNCT3_SLL:  op = ALU_SLL;
            FUNCT3_SLT:  op = ALU_SLT;
            FUNCT3_SLTU: op = ALU_SLTU;
            FUNCT3_XOR:  op = ALU_XOR;
            FUNCT3_SRL:  op = alt ? ALU_SRA : ALU_SRL;
            FUNCT3_OR:   op = ALU_OR;
            FUNCT3_AND:  op = ALU_AND;
            default:     op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_pipe_slice.sv
// Valid/ready register slice carrying a P-bit payload; payload holds its
// value while empty or stalled, valid clears on a synchronous flush.
module alu_pipe_slice #(
    parameter int P = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [P-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [P-1:0] out_data
);

    logic advance;

    assign advance = !out_valid | out_ready;

    // NOTE: the payload is reset too, because the block must present result=0 out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (advance) begin
                out_valid <= in_valid;
            end
            if (advance && in_valid && !flush) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined RV32I register-register ALU with valid/ready, tags and flush.
// Define ALU_PIPE_FLAGS_EN to add the {zero, negative, carry, overflow} flags port.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic             alt,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int SH_W = $clog2(WIDTH);
`ifdef ALU_PIPE_FLAGS_EN
    localparam int P = 4 + WIDTH + TAG_W;
`else
    localparam int P = WIDTH + TAG_W;
`endif

    alu_op_e          op;
    logic             is_sub;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result_c;
    logic [P-1:0]     payload_c;
`ifdef ALU_PIPE_FLAGS_EN
    logic             carry_c;
    logic [3:0]       flags_c;
`endif

    // SUB is folded into the adder as a + ~b + 1 so carry means "no borrow".
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        op       = alu_decode(funct3, alt);
        is_sub   = (op == ALU_SUB);
        shamt    = operand_b[SH_W-1:0];
        b_eff    = is_sub ? ~operand_b : operand_b;
`ifdef ALU_PIPE_FLAGS_EN
        {carry_c, sum} = {1'b0, operand_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
`else
        sum = operand_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
`endif
        result_c = '0;
        case (op)
            ALU_ADD, ALU_SUB: result_c = sum;
            ALU_SLL:          result_c = operand_a << shamt;
            ALU_SLT:          result_c = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU:         result_c = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            ALU_XOR:          result_c = operand_a ^ operand_b;
            ALU_SRL:          result_c = operand_a >> shamt;
            ALU_SRA:          result_c = $signed(operand_a) >>> shamt;
            ALU_OR:           result_c = operand_a | operand_b;
            ALU_AND:          result_c = operand_a & operand_b;
            default:          result_c = '0;
        endcase
`ifdef ALU_PIPE_FLAGS_EN
        flags_c    = 4'b0000;
        flags_c[3] = (result_c == '0);
        flags_c[2] = result_c[WIDTH-1];
        if (op == ALU_ADD || op == ALU_SUB) begin
            flags_c[1] = carry_c;
            flags_c[0] = (operand_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != operand_a[WIDTH-1]);
        end
        payload_c = {flags_c, result_c, in_tag};
`else
        payload_c = {result_c, in_tag};
`endif
    end

    logic [STAGES-1:0] stg_valid;
    logic [P-1:0]      stg_data [STAGES];
    logic [STAGES-1:0] down_ready;
    logic              in_advance;

    // down_ready[k] is "stage k+1 can take a new op": out_ready or any hole downstream.
    always_comb begin
        logic acc;
        acc = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            down_ready[k] = acc;
            acc = acc | !stg_valid[k];
        end
        in_advance = acc;
    end

    assign in_ready = !flush & in_advance;

    logic         v0;
    logic [P-1:0] d0;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v0 <= 1'b0;
            d0 <= '0;
        end else begin
            if (flush) begin
                v0 <= 1'b0;
            end else if (in_advance) begin
                v0 <= in_valid;
            end
            if (in_valid && in_ready) begin
                d0 <= payload_c;
            end
        end
    end

    assign stg_valid[0] = v0;
    assign stg_data[0]  = d0;

    for (genvar k = 1; k < STAGES; k++) begin : g_slice
        alu_pipe_slice #(.P(P)) u_slice (
            .clock     (clock),
            .reset_n   (reset_n),
            .flush     (flush),
            .in_valid  (stg_valid[k-1]),
            .in_data   (stg_data[k-1]),
            .out_valid (stg_valid[k]),
            .out_ready (down_ready[k]),
            .out_data  (stg_data[k])
        );
    end

    assign out_valid = stg_valid[STAGES-1];
`ifdef ALU_PIPE_FLAGS_EN
    assign {flags, result, out_tag} = stg_data[STAGES-1];
`else
    assign {result, out_tag} = stg_data[STAGES-1];
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table plus hand-written
// sequences for backpressure, flush and asynchronous reset.
module tb_alu_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       funct3 = '0;
    logic             alt = 1'b0;
    logic [WIDTH-1:0] operand_a = '0;
    logic [WIDTH-1:0] operand_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] out_tag;
`ifdef ALU_PIPE_FLAGS_EN
    logic [3:0]       flags;
`endif

    alu_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .alt       (alt),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag)
`ifdef ALU_PIPE_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [1:0]  cv;    // expected {carry, overflow}
    } vec_t;

    vec_t vecs [16];

    // Present one op with out_ready high and check latency, result, tag (and flags).
    task automatic run_vec(input int i);
        int lat;
        logic [3:0] exp_flags;
        exp_flags = {vecs[i].res == 32'd0, vecs[i].res[31], vecs[i].cv};
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        funct3    = vecs[i].f3;
        alt       = vecs[i].alt;
        operand_a = vecs[i].a;
        operand_b = vecs[i].b;
        in_tag    = TAG_W'(i);
        #1;
        check($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            #1;
            lat++;
        end
        check($sformatf("vec%0d latency", i), 64'(lat), 64'(STAGES));
        check($sformatf("vec%0d result", i), 64'(result), 64'(vecs[i].res));
        check($sformatf("vec%0d tag", i), 64'(out_tag), 64'(i));
`ifdef ALU_PIPE_FLAGS_EN
        check($sformatf("vec%0d flags", i), 64'(flags), 64'(exp_flags));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        int gaps;
        int cyc;
        int seen;
        logic [WIDTH-1:0] held;

        vecs[0]  = '{3'd0, 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 2'b00};
        vecs[1]  = '{3'd5, 1'b1, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 2'b00};
        vecs[2]  = '{3'd5, 1'b0, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 2'b00};
        vecs[3]  = '{3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 2'b00};
        vecs[4]  = '{3'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2'b00};
        vecs[5]  = '{3'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2'b10};
        vecs[6]  = '{3'd0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 2'b01};
        vecs[7]  = '{3'd0, 1'b1, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 2'b10};
        vecs[8]  = '{3'd1, 1'b0, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 2'b00};
        vecs[9]  = '{3'd4, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 2'b00};
        vecs[10] = '{3'd6, 1'b0, 32'hF0F0_F0F0, 32'h0F00_000F, 32'hFFF0_F0FF, 2'b00};
        vecs[11] = '{3'd7, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 2'b00};
        vecs[12] = '{3'd2, 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00};
        vecs[13] = '{3'd3, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 2'b00};
        vecs[14] = '{3'd5, 1'b1, 32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 2'b00};
        vecs[15] = '{3'd0, 1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 2'b00};

        // Reset state
        #22 reset_n = 1'b1;
        @(negedge clock);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 16; i++) begin
            run_vec(i);
        end

        // Backpressure: 8 ops back-to-back, consumer stalled
        @(negedge clock);
        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clock);
            in_valid  = 1'b1;
            funct3    = 3'd0;
            alt       = 1'b0;
            operand_a = WIDTH'(sent * 3);
            operand_b = 32'd100;
            in_tag    = TAG_W'(sent);
            #1;
            if (in_ready) sent++;
        end
        check("stall accepted count", 64'(sent), 64'(STAGES));
        check("stall in_ready", 64'(in_ready), 64'd0);
        check("stall out_valid", 64'(out_valid), 64'd1);
        check("stall result", 64'(result), 64'd100);
        held = result;
        @(negedge clock);
        #1;
        check("stall result hold", 64'(result), 64'(held));
        check("stall tag hold", 64'(out_tag), 64'd0);

        got = 0;
        gaps = 0;
        cyc = 0;
        while (got < 8 && cyc < 50) begin
            if (cyc > 0) @(negedge clock);
            out_ready = 1'b1;
            if (sent < 8) begin
                in_valid  = 1'b1;
                operand_a = WIDTH'(sent * 3);
                in_tag    = TAG_W'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                check($sformatf("stream result %0d", got), 64'(result), 64'(got * 3 + 100));
                check($sformatf("stream tag %0d", got), 64'(out_tag), 64'(got));
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            cyc++;
        end
        check("stream count", 64'(got), 64'd8);
        check("stream gaps", 64'(gaps), 64'd0);

        // Flush with two ops in flight and a new op presented
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sent = 0;
        cyc = 0;
        while (sent < 2 && cyc < 10) begin
            @(negedge clock);
            in_valid  = 1'b1;
            funct3    = 3'd0;
            alt       = 1'b0;
            operand_a = WIDTH'(10 + sent);
            operand_b = '0;
            in_tag    = TAG_W'(10 + sent);
            #1;
            if (in_ready) sent++;
            cyc++;
        end
        check("flush fill count", 64'(sent), 64'd2);
        @(negedge clock);
        flush  = 1'b1;
        in_tag = 5'd12;
        #1;
        check("flush in_ready", 64'(in_ready), 64'd0);
        check("flush pre out_tag", 64'(out_tag), 64'd10);
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush idle result hold", 64'(result), 64'd10);
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            if (out_valid) seen++;
        end
        check("flushed ops emerged", 64'(seen), 64'd0);

        // Asynchronous reset mid-operation
        @(negedge clock);
        in_valid  = 1'b1;
        funct3    = 3'd0;
        alt       = 1'b0;
        operand_a = 32'd1;
        operand_b = 32'd2;
        in_tag    = 5'd20;
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        check("pre-reset result", 64'(result), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset result", 64'(result), 64'd0);
        check("async reset out_tag", 64'(out_tag), 64'd0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);
        run_vec(15);

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
